// File: rtl/sdram_traffic_checker_if.sv
// Burst-level SDRAM controller port bundle: one write channel and one read channel.
// master = traffic source (checker), slave = memory controller.
interface sdram_traffic_checker_if #(
  parameter int SDR_DQ_WIDTH    = 16,
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 10
);
  logic                       wr_burst_req;
  logic [SDR_DQ_WIDTH-1:0]    wr_burst_data;
  logic [APP_BURST_WIDTH-1:0] wr_burst_len;
  logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr;
  logic                       wr_burst_data_req;
  logic                       wr_burst_finish;

  logic                       rd_burst_req;
  logic [APP_BURST_WIDTH-1:0] rd_burst_len;
  logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr;
  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data;
  logic                       rd_burst_data_valid;
  logic                       rd_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_data, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req, wr_burst_finish,
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data, rd_burst_data_valid, rd_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_data, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req, wr_burst_finish,
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data, rd_burst_data_valid, rd_burst_finish
  );
endinterface

// File: rtl/sdram_traffic_checker.sv
// SDRAM traffic checker: writes NUM_BURSTS bursts of a pattern, reads them back and counts mismatches.
// Define TRAFFIC_LFSR_PATTERN_EN for a 16-bit LFSR pattern instead of the incrementing one.
module sdram_traffic_checker #(
  parameter int                        SDR_DQ_WIDTH    = 16,
  parameter int                        APP_ADDR_WIDTH  = 24,
  parameter int                        APP_BURST_WIDTH = 10,
  parameter int                        BURST_LEN       = 1,
  parameter int                        NUM_BURSTS      = 16,
  parameter logic [APP_ADDR_WIDTH-1:0] START_ADDR      = '0,
  parameter logic [15:0]               SEED            = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  sdram_traffic_checker_if.master mem,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic                    o_led_receive_done
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE} state_t;

`ifdef TRAFFIC_LFSR_PATTERN_EN
  localparam int PAT_WIDTH = 16;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [PAT_WIDTH-1:0] pat_step(input logic [PAT_WIDTH-1:0] p);
    return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
  endfunction
`else
  localparam int PAT_WIDTH = SDR_DQ_WIDTH;

  function automatic logic [PAT_WIDTH-1:0] pat_step(input logic [PAT_WIDTH-1:0] p);
    return p + PAT_WIDTH'(1);
  endfunction
`endif

  localparam logic [PAT_WIDTH-1:0]      PAT_SEED = PAT_WIDTH'(SEED);
  localparam logic [15:0]               LAST_K   = 16'(NUM_BURSTS - 1);
  localparam logic [APP_ADDR_WIDTH-1:0] ADDR_INC = APP_ADDR_WIDTH'(BURST_LEN);

  state_t                    state_q, state_nxt;
  logic [15:0]               k_q, k_nxt;
  logic [APP_ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [PAT_WIDTH-1:0]      pat_q, pat_nxt;
  logic [15:0]               err_q, err_nxt;
  logic                      done_q, done_nxt;
  logic                      pass_q, pass_nxt;
  logic                      wr_req_q, wr_req_nxt;
  logic                      rd_req_q, rd_req_nxt;
  logic [SDR_DQ_WIDTH-1:0]   pat_word;
  logic                      in_write;

  assign pat_word = SDR_DQ_WIDTH'(pat_q);
  assign in_write = (state_q == WR_REQ) || (state_q == WR_WAIT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned (which would infer a latch); later blocking writes override.
    state_nxt  = state_q;
    k_nxt      = k_q;
    addr_nxt   = addr_q;
    pat_nxt    = pat_q;
    err_nxt    = err_q;
    done_nxt   = done_q;
    pass_nxt   = pass_q;
    wr_req_nxt = wr_req_q;
    rd_req_nxt = rd_req_q;

    if (in_write && mem.wr_burst_data_req) pat_nxt = pat_step(pat_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          k_nxt     = '0;
          addr_nxt  = START_ADDR;
          pat_nxt   = PAT_SEED;
          state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        wr_req_nxt = 1'b1;
        state_nxt  = WR_WAIT;
      end
      WR_WAIT: begin
        if (mem.wr_burst_finish) begin
          wr_req_nxt = 1'b0;
          if (k_q != LAST_K) begin
            k_nxt     = k_q + 16'd1;
            addr_nxt  = addr_q + ADDR_INC;
            state_nxt = WR_REQ;
          end else begin
            k_nxt     = '0;
            addr_nxt  = START_ADDR;
            pat_nxt   = PAT_SEED;
            state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        rd_req_nxt = 1'b1;
        state_nxt  = RD_WAIT;
      end
      RD_WAIT: begin
        // Compare first so a word arriving with finish is counted before pass is decided.
        if (mem.rd_burst_data_valid) begin
          if (mem.rd_burst_data != pat_word && err_q != 16'hFFFF) err_nxt = err_q + 16'd1;
          pat_nxt = pat_step(pat_q);
        end
        if (mem.rd_burst_finish) begin
          rd_req_nxt = 1'b0;
          if (k_q != LAST_K) begin
            k_nxt     = k_q + 16'd1;
            addr_nxt  = addr_q + ADDR_INC;
            state_nxt = RD_REQ;
          end else begin
            k_nxt     = '0;
            addr_nxt  = START_ADDR;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == 16'd0);
            state_nxt = DONE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      addr_q   <= '0;
      pat_q    <= PAT_SEED;
      err_q    <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      k_q      <= k_nxt;
      addr_q   <= addr_nxt;
      pat_q    <= pat_nxt;
      err_q    <= err_nxt;
      done_q   <= done_nxt;
      pass_q   <= pass_nxt;
      wr_req_q <= wr_req_nxt;
      rd_req_q <= rd_req_nxt;
    end
  end

  // Write data is forced to zero outside the write phase so reset drives it low.
  assign mem.wr_burst_req  = wr_req_q;
  assign mem.wr_burst_data = in_write ? pat_word : '0;
  assign mem.wr_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign mem.wr_burst_addr = addr_q;
  assign mem.rd_burst_req  = rd_req_q;
  assign mem.rd_burst_len  = APP_BURST_WIDTH'(BURST_LEN);
  assign mem.rd_burst_addr = addr_q;

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign pass               = pass_q;
  assign err_count          = err_q;
  assign o_led_receive_done = done_q & pass_q;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
// Directed-random bench: two checker instances (short linear pass, wrapping 8-word bursts)
// served by an ideal memory model; expectations come from the address/pattern formulas.
module tb_sdram_traffic_checker;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int BW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sel, start_drv, data_req, wr_finish, rd_valid, rd_finish;
  logic [DW-1:0] rd_data;
  logic          start_a, start_b;
  logic          busy_a, done_a, pass_a, led_a, busy_b, done_b, pass_b, led_b;
  logic [15:0]   err_a, err_b;

  sdram_traffic_checker_if #(.SDR_DQ_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW)) bus_a ();
  sdram_traffic_checker_if #(.SDR_DQ_WIDTH(DW), .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW)) bus_b ();

  sdram_traffic_checker #(.BURST_LEN(1), .NUM_BURSTS(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mem(bus_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .o_led_receive_done(led_a)
  );

  sdram_traffic_checker #(.BURST_LEN(8), .NUM_BURSTS(2), .START_ADDR(24'hFFFFFC)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mem(bus_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .o_led_receive_done(led_b)
  );

  // One memory model is steered to whichever instance sel picks.
  assign start_a = start_drv & ~sel;
  assign start_b = start_drv & sel;
  assign bus_a.wr_burst_data_req   = data_req & ~sel;
  assign bus_a.wr_burst_finish     = wr_finish & ~sel;
  assign bus_a.rd_burst_data_valid = rd_valid & ~sel;
  assign bus_a.rd_burst_finish     = rd_finish & ~sel;
  assign bus_a.rd_burst_data       = rd_data;
  assign bus_b.wr_burst_data_req   = data_req & sel;
  assign bus_b.wr_burst_finish     = wr_finish & sel;
  assign bus_b.rd_burst_data_valid = rd_valid & sel;
  assign bus_b.rd_burst_finish     = rd_finish & sel;
  assign bus_b.rd_burst_data       = rd_data;

  logic          o_wr_req, o_rd_req, o_busy, o_done, o_pass, o_led;
  logic [DW-1:0] o_wr_data;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [BW-1:0] o_wr_len, o_rd_len;
  logic [15:0]   o_err;

  assign o_wr_req  = sel ? bus_b.wr_burst_req  : bus_a.wr_burst_req;
  assign o_rd_req  = sel ? bus_b.rd_burst_req  : bus_a.rd_burst_req;
  assign o_wr_data = sel ? bus_b.wr_burst_data : bus_a.wr_burst_data;
  assign o_wr_addr = sel ? bus_b.wr_burst_addr : bus_a.wr_burst_addr;
  assign o_rd_addr = sel ? bus_b.rd_burst_addr : bus_a.rd_burst_addr;
  assign o_wr_len  = sel ? bus_b.wr_burst_len  : bus_a.wr_burst_len;
  assign o_rd_len  = sel ? bus_b.rd_burst_len  : bus_a.rd_burst_len;
  assign o_busy    = sel ? busy_b : busy_a;
  assign o_done    = sel ? done_b : done_a;
  assign o_pass    = sel ? pass_b : pass_a;
  assign o_led     = sel ? led_b  : led_a;
  assign o_err     = sel ? err_b  : err_a;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cfg_bl, cfg_nb;
  logic [31:0] cfg_start;
  logic [DW-1:0] wmem [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input bit rd);
    int t = 0;
    while (((rd ? o_rd_req : o_wr_req) !== 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(rd ? o_rd_req : o_wr_req), 32'd1);
  endtask

  function automatic logic [31:0] exp_addr(input int b);
    return (cfg_start + 32'(b * cfg_bl)) & 32'h00FF_FFFF;
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    return (32'hACE1 + 32'(i)) & 32'h0000_FFFF;
  endfunction

  // One full pass: start, serve every write burst, then serve every read burst.
  task automatic run_pass(input int corrupt, input bit poke_start, input bit stray,
                          input bit last_together);
    int  i;
    bit  together;
    int  exp_err;
    @(negedge clk) start_drv = 1'b1;
    @(negedge clk) start_drv = 1'b0;

    for (int b = 0; b < cfg_nb; b++) begin
      wait_req("wr_req_rise", 1'b0);
      check("wr_addr", 32'(o_wr_addr), exp_addr(b));
      check("wr_len", 32'(o_wr_len), 32'(cfg_bl));
      if (stray && b == 0) begin
        rd_valid = 1'b1;
        rd_data  = 16'h5A5A;
        @(negedge clk);
        rd_valid = 1'b0;
      end
      for (int j = 0; j < cfg_bl; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i = b * cfg_bl + j;
        check("wr_data", 32'(o_wr_data), exp_word(i));
        wmem[i]  = o_wr_data;
        data_req = 1'b1;
        @(negedge clk);
        data_req = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wr_finish = 1'b1;
      @(negedge clk);
      wr_finish = 1'b0;
      check("wr_req_fall", 32'(o_wr_req), 32'd0);
    end

    for (int b = 0; b < cfg_nb; b++) begin
      wait_req("rd_req_rise", 1'b1);
      check("rd_addr", 32'(o_rd_addr), exp_addr(b));
      check("rd_len", 32'(o_rd_len), 32'(cfg_bl));
      if (poke_start && b == 0) begin
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
      end
      together = 1'b0;
      for (int j = 0; j < cfg_bl; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        i        = b * cfg_bl + j;
        together = last_together && (b == cfg_nb - 1) && (j == cfg_bl - 1);
        rd_valid = 1'b1;
        rd_data  = wmem[i] ^ ((i == corrupt) ? 16'h0001 : 16'h0000);
        if (together) rd_finish = 1'b1;
        @(negedge clk);
        rd_valid  = 1'b0;
        rd_finish = 1'b0;
        rd_data   = 16'($urandom);
      end
      if (!together) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rd_finish = 1'b1;
        @(negedge clk);
        rd_finish = 1'b0;
      end
      if (b < cfg_nb - 1) check("rd_req_fall", 32'(o_rd_req), 32'd0);
    end

    exp_err = (corrupt >= 0 && corrupt < cfg_nb * cfg_bl) ? 1 : 0;
    check("done_set", 32'(o_done), 32'd1);
    check("pass", 32'(o_pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check("led", 32'(o_led), (exp_err == 0) ? 32'd1 : 32'd0);
    check("err_count", 32'(o_err), 32'(exp_err));
    check("busy_in_done", 32'(o_busy), 32'd1);
    check("rd_req_final", 32'(o_rd_req), 32'd0);
    @(negedge clk);
    check("busy_back_idle", 32'(o_busy), 32'd0);
    check("done_sticky", 32'(o_done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; sel = 1'b0; start_drv = 1'b0; data_req = 1'b0;
    wr_finish = 1'b0; rd_valid = 1'b0; rd_finish = 1'b0; rd_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_pass", 32'(o_pass), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_led", 32'(o_led), 32'd0);
    check("rst_wr_req", 32'(o_wr_req), 32'd0);
    check("rst_rd_req", 32'(o_rd_req), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("no_start_idle", 32'(o_busy), 32'd0);

    // Instance A: 4 single-word bursts from address 0
    cfg_bl = 1; cfg_nb = 4; cfg_start = 32'd0;
    run_pass(-1, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("start_in_read_ignored", 32'(o_busy), 32'd0);
    check("done_still_set", 32'(o_done), 32'd1);

    // Corrupt word 3, delivered together with the final finish
    run_pass(3, 1'b0, 1'b0, 1'b1);
    rd_valid = 1'b1;
    rd_data  = 16'h0BAD;
    @(negedge clk);
    rd_valid = 1'b0;
    check("idle_valid_ignored", 32'(o_err), 32'd1);

    // Asynchronous reset in the middle of a write burst
    @(negedge clk) start_drv = 1'b1;
    @(negedge clk) start_drv = 1'b0;
    wait_req("mid_wr_req_rise", 1'b0);
    data_req = 1'b1;
    @(negedge clk);
    data_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_wr_req", 32'(o_wr_req), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_err", 32'(o_err), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("midrst_wr_data", 32'(o_wr_data), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(o_busy), 32'd0);

    // Instance B: two 8-word bursts wrapping past the top of the address space
    sel = 1'b1;
    cfg_bl = 8; cfg_nb = 2; cfg_start = 32'h00FF_FFFC;
    @(negedge clk);
    run_pass(-1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    run_pass(int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
